mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/s_proc_pkg.sv | 23 ++
 rtl/mem_arb_timer.sv | 30 +++
 rtl/mem_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/s_proc_pkg.sv
// Shared encodings for the CPU/DMA memory arbiter: FSM states, access direction, requester IDs.
// Also carries the round-robin winner pick so the policy lives in one place.
package s_proc_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DMA = 1'b1;

   // On a tie the requester that was not granted last wins; result is a don't-care with no request.
   function automatic logic pick_winner(input logic cpu_req, input logic dma_req,
                                        input logic last_winner);
      if (cpu_req && dma_req)
         return ~last_winner;
      return dma_req ? REQ_DMA : REQ_CPU;
   endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// ACCESS watchdog: counts cycles without mem_rdy, flags the cycle whose increment reaches TIMEOUT.
// Latency: expired is combinational from the count; backpressure: none, enable simply stalls the count.
// Clear has priority over enable.
module mem_arb_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic clr,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && !expired)
         count <= count + CW'(1);
   end

   // Looking one step ahead keeps ACCESS at exactly TIMEOUT cycles when mem_rdy never arrives.
   assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin CPU/DMA arbiter for one shared memory port (IDLE -> ACCESS -> RESP).
// Latency: done two cycles after req is sampled when mem_rdy comes in the first ACCESS cycle.
// Backpressure: mem_rdy holds ACCESS up to TIMEOUT cycles, then completes with err; req held until done.
module mem_arbiter
   import s_proc_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              cpu_req,
   input  logic              dma_req,
   input  logic              cpu_rw,
   input  logic              dma_rw,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              cpu_gnt,
   output logic              dma_gnt,
   output logic              cpu_done,
   output logic              dma_done,
   output logic              cpu_err,
   output logic              dma_err,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_cs,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rdy
);

   logic [1:0]        state;
   logic              last_winner;
   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              err_q;
   logic              win;
   logic              tmr_expired;
   logic              in_access;
   logic              in_resp;

   assign win       = pick_winner(cpu_req, dma_req, last_winner);
   assign in_access = (state == ST_ACCESS);
   assign in_resp   = (state == ST_RESP);

   mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .clr     (clr),
      .clear   (!in_access),
      .enable  (in_access && !mem_rdy),
      .expired (tmr_expired)
   );

   // last_winner doubles as the owner of the transaction in flight.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state       <= ST_IDLE;
         last_winner <= REQ_DMA;
         rw_q        <= RW_READ;
         addr_q      <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         cpu_rdata   <= '0;
         dma_rdata   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cpu_req || dma_req) begin
                  state       <= ST_ACCESS;
                  last_winner <= win;
                  rw_q        <= (win == REQ_DMA) ? dma_rw    : cpu_rw;
                  addr_q      <= (win == REQ_DMA) ? dma_addr  : cpu_addr;
                  wdata_q     <= (win == REQ_DMA) ? dma_wdata : cpu_wdata;
               end
            end
            ST_ACCESS: begin
               if (mem_rdy) begin
                  state <= ST_RESP;
                  err_q <= 1'b0;
                  if (rw_q == RW_READ) begin
                     if (last_winner == REQ_DMA)
                        dma_rdata <= mem_rdata;
                     else
                        cpu_rdata <= mem_rdata;
                  end
               end else if (tmr_expired) begin
                  state <= ST_RESP;
                  err_q <= 1'b1;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign mem_cs    = in_access;
   assign mem_rw    = rw_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   assign cpu_gnt  = (in_access || in_resp) && (last_winner == REQ_CPU);
   assign dma_gnt  = (in_access || in_resp) && (last_winner == REQ_DMA);
   assign cpu_done = in_resp && (last_winner == REQ_CPU);
   assign dma_done = in_resp && (last_winner == REQ_DMA);
   assign cpu_err  = cpu_done && err_q;
   assign dma_err  = dma_done && err_q;

endmodule
